btn_fltr_multi: RTL

- Parametrised multi-channel successor to the single-button filter. Each channel has an input synchroniser, a CE-paced debounce counter, and press/release edge pulses.
- Adds a per-channel auto-repeat generator: when a button is held, `BTN_RPT` emits a pulse on the press and then periodic repeat pulses.
- Sits between the board push-buttons and the UI/control logic. Shares the system CE tick with the other slow-timing blocks.

---
 rtl/btn_fltr_pkg.sv | 18 +
 rtl/btn_fltr_ch.sv | 117 +++++++++++
 rtl/btn_fltr_multi.sv | 43 ++++
 3 files changed

// File: rtl/btn_fltr_pkg.sv
// Shared state encoding and default timing for the multi-channel button filter.
package btn_fltr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RPT     = 2'd3
  } st_e;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_RPT_DLY     = 8;
  localparam int DEF_RPT_PER     = 4;
  localparam int DEF_RPT_W       = 8;

endpackage

// File: rtl/btn_fltr_ch.sv
// One button channel: synchroniser, CE-paced debounce, edge pulses and auto-repeat FSM.
module btn_fltr_ch
  import btn_fltr_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RPT_DLY     = DEF_RPT_DLY,
  parameter int RPT_PER     = DEF_RPT_PER,
  parameter int RPT_W       = DEF_RPT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic rpt_en_i,
  input  logic btn_i,
  output logic btn_o,
  output logic press_o,
  output logic rel_o,
  output logic rpt_o
);

  localparam logic [RPT_W-1:0] DLY_TC = RPT_W'(RPT_DLY - 1);
  localparam logic [RPT_W-1:0] PER_TC = RPT_W'(RPT_PER - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [RPT_W-1:0]       rc_q;
  st_e                    st_q;
  logic                   btn_q, press_q, rel_q, rpt_q;
  logic                   s, evt;

  assign s   = sync_q[SYNC_STAGES-1];
  assign evt = (&cnt_q) & ce_i & (s != btn_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      rc_q    <= '0;
      st_q    <= ST_IDLE;
      btn_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;

      // On evt cnt wraps to zero, and s == btn_q keeps it cleared afterwards.
      if (s == btn_q)  cnt_q <= '0;
      else if (ce_i)   cnt_q <= cnt_q + CNT_W'(1);

      if (evt) begin
        btn_q   <= s;
        press_q <= s;
        rel_q   <= ~s;
      end

      if (evt && !s) begin
        // Release beats any repeat terminal count in the same cycle.
        st_q <= ST_IDLE;
        rc_q <= '0;
      end else begin
        case (st_q)
          ST_IDLE: if (evt) begin
            rpt_q <= 1'b1;
            rc_q  <= '0;
            st_q  <= rpt_en_i ? ST_HOLD : ST_PRESSED;
          end
          ST_PRESSED: if (rpt_en_i) begin
            st_q <= ST_HOLD;
            rc_q <= '0;
          end
          ST_HOLD: begin
            if (!rpt_en_i) begin
              st_q <= ST_PRESSED;
              rc_q <= '0;
            end else if (ce_i) begin
              if (rc_q == DLY_TC) begin
                rpt_q <= 1'b1;
                rc_q  <= '0;
                st_q  <= ST_RPT;
              end else begin
                rc_q <= rc_q + RPT_W'(1);
              end
            end
          end
          ST_RPT: begin
            if (!rpt_en_i) begin
              st_q <= ST_PRESSED;
              rc_q <= '0;
            end else if (ce_i) begin
              if (rc_q == PER_TC) begin
                rpt_q <= 1'b1;
                rc_q  <= '0;
              end else begin
                rc_q <= rc_q + RPT_W'(1);
              end
            end
          end
          default: begin
            st_q <= ST_IDLE;
            rc_q <= '0;
          end
        endcase
      end
    end
  end

  assign btn_o   = btn_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign rpt_o   = rpt_q;

endmodule

// File: rtl/btn_fltr_multi.sv
// N_CH independent debounced buttons with press/release pulses and auto-repeat.
module btn_fltr_multi
  import btn_fltr_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RPT_DLY     = DEF_RPT_DLY,
  parameter int RPT_PER     = DEF_RPT_PER,
  parameter int RPT_W       = DEF_RPT_W
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CE,
  input  logic [N_CH-1:0] RPT_EN,
  input  logic [N_CH-1:0] BTN_I,
  output logic [N_CH-1:0] BTN_O,
  output logic [N_CH-1:0] BTN_PRESS,
  output logic [N_CH-1:0] BTN_REL,
  output logic [N_CH-1:0] BTN_RPT
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_fltr_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .RPT_DLY    (RPT_DLY),
      .RPT_PER    (RPT_PER),
      .RPT_W      (RPT_W)
    ) u_ch (
      .clk_i   (CLK),
      .rst_i   (RST),
      .ce_i    (CE),
      .rpt_en_i(RPT_EN[g]),
      .btn_i   (BTN_I[g]),
      .btn_o   (BTN_O[g]),
      .press_o (BTN_PRESS[g]),
      .rel_o   (BTN_REL[g]),
      .rpt_o   (BTN_RPT[g])
    );
  end

endmodule
